osd_glyph_fetch: RTL and testbench

Sequencer that sits in front of the OSD ASCII character ROM (2048 × 9, 128 glyphs × 16 rows × 9 pixels) in the udp_osd path. It accepts glyph-row requests (character code, row) from the OSD text scanner and drives the ROM address. It captures the returned 9-bit row, then serializes it as a one-pixel-per-cycle valid/ready stream toward the overlay mixer. It keeps two rows in flight, so back-to-back requests produce a gap-free pixel stream.

---
 rtl/osd_pkg.sv | 29 ++
 rtl/osd_glyph_shifter.sv | 115 +++++++++++
 rtl/osd_glyph_fetch.sv | 86 ++++++++
 tb/tb_osd_glyph_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD glyph fetch path.
// OSD_GLYPH_ROM_OREG_EN selects the character ROM with its output register (two-cycle read).
package osd_pkg;

    localparam int unsigned CHAR_W     = 7;
    localparam int unsigned ROW_W      = 4;
    localparam int unsigned DATA_W     = 9;
    localparam int unsigned GLYPH_ROWS = 16;

    // Rows that may be in flight, parked in the skid register, or shifting.
    localparam int unsigned CREDITS = 2;

`ifdef OSD_GLYPH_ROM_OREG_EN
    localparam int unsigned ROM_LAT = 2;
`else
    localparam int unsigned ROM_LAT = 1;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } glyph_row_t;

    typedef enum logic {
        SHF_IDLE  = 1'b0,
        SHF_SHIFT = 1'b1
    } shf_state_t;

endpackage

// File: rtl/osd_glyph_shifter.sv
// Glyph-row serializer: one-row skid register plus MSB-first pixel shifter
// with a valid/ready handshake toward the overlay mixer.
module osd_glyph_shifter
    import osd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  glyph_row_t in_row,
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic       pix_bit,
    output logic       pix_last,
    output logic       pix_eol,
    output logic       row_done_c
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    shf_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              cur_last;
    glyph_row_t        skid;
    logic              skid_vld;

    logic              hs_c;
    logic              free_c;
    logic              load_c;
    glyph_row_t        load_row_c;

    // The shifter can take a new row when idle or while its last pixel is being taken.
    always_comb begin
        hs_c       = pix_valid && pix_ready;
        row_done_c = hs_c && pix_last;
        free_c     = (state == SHF_IDLE) || row_done_c;
        load_c     = free_c && (skid_vld || in_valid);
        load_row_c = skid_vld ? skid : in_row;
    end

    // The current pixel is always the top bit of the shift register.
    assign pix_bit = shreg[DATA_W-1];

    // Skid register: parks a returning row while the shifter is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid     <= '0;
            skid_vld <= 1'b0;
        end else if (in_valid && !free_c) begin
            skid     <= in_row;
            skid_vld <= 1'b1;
        end else if (load_c && skid_vld) begin
            skid_vld <= 1'b0;
        end
    end

    // Shifter FSM with registered pixel outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SHF_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            cur_last  <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            pix_eol   <= 1'b0;
        end else begin
            case (state)
                SHF_IDLE: begin
                    if (load_c) begin
                        state     <= SHF_SHIFT;
                        shreg     <= load_row_c.data;
                        cur_last  <= load_row_c.last;
                        bit_cnt   <= CNT_W'(DATA_W - 1);
                        pix_valid <= 1'b1;
                        pix_last  <= 1'b0;
                        pix_eol   <= 1'b0;
                    end
                end
                SHF_SHIFT: begin
                    if (row_done_c) begin
                        if (load_c) begin
                            shreg     <= load_row_c.data;
                            cur_last  <= load_row_c.last;
                            bit_cnt   <= CNT_W'(DATA_W - 1);
                            pix_valid <= 1'b1;
                            pix_last  <= 1'b0;
                            pix_eol   <= 1'b0;
                        end else begin
                            state     <= SHF_IDLE;
                            shreg     <= '0;
                            cur_last  <= 1'b0;
                            bit_cnt   <= '0;
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            pix_eol   <= 1'b0;
                        end
                    end else if (hs_c) begin
                        shreg    <= {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt  <= bit_cnt - CNT_W'(1);
                        pix_last <= (bit_cnt == CNT_W'(1));
                        pix_eol  <= (bit_cnt == CNT_W'(1)) && cur_last;
                    end
                end
                default: begin
                    state     <= SHF_IDLE;
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    pix_eol   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/osd_glyph_fetch.sv
// Glyph-row fetch sequencer: credit counter, ROM address register and read-latency pipe.
// Define OSD_GLYPH_ROM_OREG_EN when the character ROM has its output register enabled.
module osd_glyph_fetch #(
    parameter int unsigned CHAR_W = 7,
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CHAR_W-1:0] req_char,
    input  logic [ROW_W-1:0]  req_row,
    input  logic              req_last,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_bit,
    output logic              pix_last,
    output logic              pix_eol
);

    import osd_pkg::*;

    // Stage 0 marks the cycle rom_addr is presented; the top stage marks valid rom_data.
    localparam int unsigned PIPE_D = ROM_LAT + 1;

    logic [1:0]        occ;
    logic [PIPE_D-1:0] pipe_vld;
    logic [PIPE_D-1:0] pipe_last;
    logic              accept_c;
    logic              row_done_c;
    glyph_row_t        cap_row_c;

    assign req_ready = (occ < 2'(CREDITS)) && !rst;

    always_comb begin
        accept_c       = req_valid && req_ready;
        cap_row_c.data = rom_data;
        cap_row_c.last = pipe_last[PIPE_D-1];
    end

    // Credits: a row is charged on accept and refunded when its last pixel is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({accept_c, row_done_c})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Address register and read-latency pipe; reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr  <= '0;
            pipe_vld  <= '0;
            pipe_last <= '0;
        end else begin
            if (accept_c) begin
                rom_addr <= ADDR_W'({req_char, req_row});
            end
            pipe_vld  <= {pipe_vld[PIPE_D-2:0], accept_c};
            pipe_last <= {pipe_last[PIPE_D-2:0], accept_c && req_last};
        end
    end

    osd_glyph_shifter u_shf (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (pipe_vld[PIPE_D-1]),
        .in_row     (cap_row_c),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_bit    (pix_bit),
        .pix_last   (pix_last),
        .pix_eol    (pix_eol),
        .row_done_c (row_done_c)
    );

endmodule

// File: tb/tb_osd_glyph_fetch.sv
// Bench for osd_glyph_fetch: synchronous ROM model, row-queue reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_osd_glyph_fetch;
    import osd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_char = '0;
    logic [3:0]  req_row = '0;
    logic        req_last = 1'b0;
    logic [10:0] rom_addr;
    logic [8:0]  rom_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_bit;
    logic        pix_last;
    logic        pix_eol;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    osd_glyph_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_char  (req_char),
        .req_row   (req_row),
        .req_last  (req_last),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_bit   (pix_bit),
        .pix_last  (pix_last),
        .pix_eol   (pix_eol)
    );

    // Character ROM: registered address, optional output register.
    logic [8:0] rom [0:2047];
    logic [8:0] rom_q1;
    always @(posedge clk) rom_q1 <= rom[rom_addr];
`ifdef OSD_GLYPH_ROM_OREG_EN
    logic [8:0] rom_q2;
    always @(posedge clk) rom_q2 <= rom_q1;
    assign rom_data = rom_q2;
    localparam int EXP_LAT = 3;
`else
    assign rom_data = rom_q1;
    localparam int EXP_LAT = 2;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rows queue up with the edge at which their data is usable.
    typedef struct {
        logic [8:0] data;
        logic       last;
        int         arr;
    } mrow_t;

    mrow_t       m_q[$];
    mrow_t       m_cur;
    int          m_occ = 0;
    bit          m_act = 0;
    int          m_bit = 0;
    logic [10:0] m_addr = '0;
    int          cyc = 0;
    int          acc_cnt = 0;

    always @(posedge clk) begin
        bit hs;
        bit acc;
        cyc++;
        if (rst) begin
            m_q.delete();
            m_occ  = 0;
            m_act  = 0;
            m_bit  = 0;
            m_addr = '0;
        end else begin
            hs  = m_act && pix_ready;
            acc = req_valid && (m_occ < 2);
            if (acc) acc_cnt++;
            if (hs) begin
                if (m_bit == 0) begin
                    m_act = 0;
                    m_occ--;
                end else begin
                    m_bit--;
                end
            end
            if (acc) begin
                m_occ++;
                m_addr = {req_char, req_row};
                m_q.push_back('{rom[m_addr], req_last, cyc + ROM_LAT + 1});
            end
            if (!m_act && m_q.size() > 0 && m_q[0].arr <= cyc) begin
                m_cur = m_q.pop_front();
                m_act = 1;
                m_bit = 8;
            end
        end
    end

    // Per-cycle compare plus logs used by the literal checks.
    logic pix_log[$];
    int   max_run = 0;
    int   run = 0;
    int   eol_cnt = 0;
    int   eol_idx = -1;
    int   vld_cnt = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst) begin
                check("rst_req_ready", int'(req_ready), 0);
                check("rst_rom_addr", int'(rom_addr), 0);
                check("rst_pix_valid", int'(pix_valid), 0);
                check("rst_pix_bit", int'(pix_bit), 0);
                check("rst_pix_last", int'(pix_last), 0);
                check("rst_pix_eol", int'(pix_eol), 0);
            end else begin
                check("req_ready", int'(req_ready), int'(m_occ < 2));
                check("rom_addr", int'(rom_addr), int'(m_addr));
                check("pix_valid", int'(pix_valid), int'(m_act));
                if (m_act) begin
                    check("pix_bit", int'(pix_bit), int'(m_cur.data[m_bit]));
                    check("pix_last", int'(pix_last), int'(m_bit == 0));
                    check("pix_eol", int'(pix_eol), int'(m_bit == 0 && m_cur.last));
                end
                if (dut.u_shf.in_valid) check("skid_free_on_return", int'(dut.u_shf.skid_vld), 0);
                if (pix_valid) begin
                    run++;
                    vld_cnt++;
                    if (run > max_run) max_run = run;
                end else begin
                    run = 0;
                end
                if (pix_valid && pix_ready) begin
                    if (pix_eol) begin
                        eol_cnt++;
                        eol_idx = pix_log.size();
                    end
                    pix_log.push_back(pix_bit);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [6:0] c, input logic [3:0] r, input logic l);
        int   g = 0;
        logic took = 1'b0;
        req_valid = 1'b1;
        req_char  = c;
        req_row   = r;
        req_last  = l;
        while (!took && g < 200) begin
            took = req_ready;
            step();
            g++;
        end
        check("accept_in_time", int'(took), 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((m_occ != 0 || m_act || pix_valid) && g < 200) begin
            step();
            g++;
        end
        check("drain_in_time", int'(g < 200), 1);
        step();
    endtask

    task automatic check_row(input string name, input logic [8:0] word, input int base);
        for (int i = 0; i < 9; i++) begin
            check(name, int'(pix_log[base + i]), int'(word[8 - i]));
        end
    endtask

    task automatic check_latency(input string name);
        int lat = 0;
        while (!pix_valid && lat < 10) begin
            step();
            lat++;
        end
        check(name, lat, EXP_LAT);
    endtask

    initial begin
        logic [8:0] snap_word;
        logic       snap_bit;
        int         g;

        for (int i = 0; i < 2048; i++) rom[i] = 9'((i * 37 + 11) ^ (i >> 4));
        rom[11'h415] = 9'h1A5;
        rom[11'h302] = 9'h0F3;

        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Single request: char 0x41 row 5 -> word 0x1A5.
        pix_log.delete();
        send(7'h41, 4'h5, 1'b0);
        req_valid = 1'b0;
        check("t1_rom_addr", int'(rom_addr), 'h415);
        check_latency("t1_latency");
        wait_idle();
        check("t1_npix", pix_log.size(), 9);
        if (pix_log.size() == 9) check_row("t1_pix", 9'h1A5, 0);

        // Streaming: eight back-to-back rows, no gaps.
        pix_log.delete();
        max_run = 0;
        for (int i = 0; i < 8; i++) send(7'(i + 16), 4'(i), 1'b0);
        req_valid = 1'b0;
        wait_idle();
        check("t2_run", max_run, 72);
        check("t2_npix", pix_log.size(), 72);

        // Backpressure with two rows held and a third request waiting.
        pix_log.delete();
        send(7'h50, 4'h1, 1'b0);
        send(7'h51, 4'h2, 1'b0);
        repeat (4) step();
        pix_ready = 1'b0;
        req_valid = 1'b1;
        req_char  = 7'h52;
        req_row   = 4'h3;
        req_last  = 1'b0;
        acc_cnt   = 0;
        snap_bit  = pix_bit;
        repeat (20) step();
        check("t3_no_third_accept", acc_cnt, 0);
        check("t3_frozen_valid", int'(pix_valid), 1);
        check("t3_frozen_bit", int'(pix_bit), int'(snap_bit));
        check("t3_skid_full", int'(dut.u_shf.skid_vld), 1);
        snap_word = rom[11'h512];
        check("t3_skid_row2", int'(dut.u_shf.skid.data), int'(snap_word));
        pix_ready = 1'b1;
        send(7'h52, 4'h3, 1'b0);
        req_valid = 1'b0;
        wait_idle();
        check("t3_npix", pix_log.size(), 27);

        // Accept on the same edge as a bit-0 handshake.
        pix_log.delete();
        send(7'h22, 4'h3, 1'b0);
        req_valid = 1'b0;
        g = 0;
        while (!(pix_valid && pix_last) && g < 50) begin
            step();
            g++;
        end
        check("t4_reach_bit0", int'(g < 50), 1);
        send(7'h23, 4'h4, 1'b0);
        req_valid = 1'b0;
        check("t4_req_ready", int'(req_ready), 1);
        check("t4_occ", int'(dut.occ), 1);
        wait_idle();
        check("t4_npix", pix_log.size(), 18);

        // End of line on the third request.
        pix_log.delete();
        eol_cnt = 0;
        eol_idx = -1;
        send(7'h01, 4'h0, 1'b0);
        send(7'h02, 4'h0, 1'b0);
        send(7'h03, 4'h0, 1'b1);
        req_valid = 1'b0;
        wait_idle();
        check("t5_eol_count", eol_cnt, 1);
        check("t5_eol_position", eol_idx, 26);

        // Reset during pixel 4 of row 1 with row 2 in flight.
        send(7'h60, 4'h7, 1'b0);
        send(7'h61, 4'h8, 1'b0);
        req_valid = 1'b0;
        g = 0;
        while (!pix_valid && g < 10) begin
            step();
            g++;
        end
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("t6_pix_valid", int'(pix_valid), 0);
        check("t6_rom_addr", int'(rom_addr), 0);
        check("t6_req_ready", int'(req_ready), 0);
        step();
        step();
        rst = 1'b0;
        vld_cnt = 0;
        repeat (10) step();
        check("t6_no_stale_pixels", vld_cnt, 0);
        pix_log.delete();
        send(7'h30, 4'h2, 1'b0);
        req_valid = 1'b0;
        check("t6_rom_addr_after", int'(rom_addr), 'h302);
        check_latency("t6_latency");
        wait_idle();
        check("t6_npix", pix_log.size(), 9);
        if (pix_log.size() == 9) check_row("t6_pix", 9'h0F3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
